// File: rtl/stack_cpu_core.sv
// stack_cpu_core: multicycle control and datapath for an 8-bit stack machine.
// Every instruction is fetched from the unified 32x8 memory in FETCH and
// executed in EXEC. Execution uses an internal operand stack of DEPTH entries.
// A stack overflow or underflow halts the core until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   run_i        level start request, sampled only in IDLE
//   mem_addr_o   memory address
//   mem_write_o  memory write enable (memory writes on posedge clk)
//   mem_read_o   memory read enable
//   mem_wdata_o  memory write data (0 unless writing)
//   mem_rdata_i  combinational memory read data
//   pc_o         program counter
//   tos_o        top of stack (0 when empty)
//   sp_count_o   number of valid stack entries
//   instr_done_o pulse in the EXEC cycle of an instruction that completes
//   stack_err_o  sticky overflow/underflow flag
//   halted_o     high in HALT
module stack_cpu_core #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SPW   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run_i,
    output logic [4:0]     mem_addr_o,
    output logic           mem_write_o,
    output logic           mem_read_o,
    output logic [7:0]     mem_wdata_o,
    input  logic [7:0]     mem_rdata_i,
    output logic [4:0]     pc_o,
    output logic [7:0]     tos_o,
    output logic [SPW-1:0] sp_count_o,
    output logic           instr_done_o,
    output logic           stack_err_o,
    output logic           halted_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpNot  = 3'd3;
    localparam logic [2:0] OpPush = 3'd4;
    localparam logic [2:0] OpPop  = 3'd5;
    localparam logic [2:0] OpJmp  = 3'd6;
    localparam logic [2:0] OpJz   = 3'd7;

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    state_e         state_q, state_d;
    logic [4:0]     pc_q, pc_d;
    logic [7:0]     ir_q, ir_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;

    logic [7:0]     stk_q [DEPTH];
    logic           stk_we;
    logic [IdxW-1:0] stk_widx;
    logic [7:0]     stk_wdata;

    logic [2:0]      op;
    logic [4:0]      addr;
    logic [IdxW-1:0] top_idx, nxt_idx, push_idx;
    logic [7:0]      top_val, nxt_val, alu_res;
    logic            exec_err;

    assign op   = ir_q[7:5];
    assign addr = ir_q[4:0];

    // Entry k holds the (k+1)-th oldest operand; the top lives at sp-1.
    assign top_idx  = IdxW'(sp_q - SPW'(1));
    assign nxt_idx  = IdxW'(sp_q - SPW'(2));
    assign push_idx = IdxW'(sp_q);
    assign top_val  = (sp_q == '0) ? 8'h00 : stk_q[top_idx];
    assign nxt_val  = stk_q[nxt_idx];

    // B is the older operand, A the newest: result = B op A.
    always_comb begin
        alu_res = 8'h00;
        unique case (op)
            OpAdd:   alu_res = nxt_val + top_val;
            OpSub:   alu_res = nxt_val - top_val;
            OpAnd:   alu_res = nxt_val & top_val;
            default: alu_res = 8'h00;
        endcase
    end

    always_comb begin
        exec_err = 1'b0;
        unique case (op)
            OpAdd, OpSub, OpAnd:  exec_err = (sp_q < SPW'(2));
            OpNot, OpPop, OpJz:   exec_err = (sp_q == '0);
            OpPush:               exec_err = (sp_q == SPW'(DEPTH));
            default:              exec_err = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        sp_d         = sp_q;
        err_d        = err_q;
        mem_addr_o   = 5'd0;
        mem_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_wdata_o  = 8'h00;
        instr_done_o = 1'b0;
        stk_we       = 1'b0;
        stk_widx     = '0;
        stk_wdata    = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (run_i) state_d = StFetch;
            end
            StFetch: begin
                mem_read_o = 1'b1;
                mem_addr_o = pc_q;
                ir_d       = mem_rdata_i;
                pc_d       = pc_q + 5'd1;
                state_d    = StExec;
            end
            StExec: begin
                if (exec_err) begin
                    // Faulting instruction has no side effects besides the flag.
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    instr_done_o = 1'b1;
                    state_d      = StFetch;
                    unique case (op)
                        OpPush: begin
                            mem_read_o = 1'b1;
                            mem_addr_o = addr;
                            stk_we     = 1'b1;
                            stk_widx   = push_idx;
                            stk_wdata  = mem_rdata_i;
                            sp_d       = sp_q + SPW'(1);
                        end
                        OpPop: begin
                            mem_write_o = 1'b1;
                            mem_addr_o  = addr;
                            mem_wdata_o = top_val;
                            sp_d        = sp_q - SPW'(1);
                        end
                        OpAdd, OpSub, OpAnd: begin
                            stk_we    = 1'b1;
                            stk_widx  = nxt_idx;
                            stk_wdata = alu_res;
                            sp_d      = sp_q - SPW'(1);
                        end
                        OpNot: begin
                            stk_we    = 1'b1;
                            stk_widx  = top_idx;
                            stk_wdata = ~top_val;
                        end
                        OpJmp: pc_d = addr;
                        OpJz: begin
                            if (top_val == 8'h00) pc_d = addr;
                        end
                        default: ;
                    endcase
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= 5'd0;
            ir_q    <= 8'h00;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; only entries below sp are ever observed.
    always_ff @(posedge clk) begin
        if (stk_we) stk_q[stk_widx] <= stk_wdata;
    end

    assign pc_o        = pc_q;
    assign tos_o       = top_val;
    assign sp_count_o  = sp_q;
    assign stack_err_o = err_q;
    assign halted_o    = (state_q == StHalt);

endmodule

// File: tb/tb_stack_cpu_core.sv
// Self-checking bench for stack_cpu_core with a 32x8 memory model.
module tb_stack_cpu_core;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [4:0] mem_addr;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [4:0] pc;
    logic [7:0] tos;
    logic [3:0] sp_count;
    logic       instr_done;
    logic       stack_err;
    logic       halted;

    stack_cpu_core #(.DEPTH(8), .SPW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .mem_addr_o  (mem_addr),
        .mem_write_o (mem_write),
        .mem_read_o  (mem_read),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .pc_o        (pc),
        .tos_o       (tos),
        .sp_count_o  (sp_count),
        .instr_done_o(instr_done),
        .stack_err_o (stack_err),
        .halted_o    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: image loaded while ld_en is high, otherwise DUT writes.
    logic [7:0] mem [32];
    logic [7:0] img [32];
    logic       ld_en;
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int done_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_cnt <= 0;
        else if (instr_done) done_cnt <= done_cnt + 1;
    end

    int n_cmp;
    int n_bad;

    typedef struct {
        int         prog;
        logic [4:0] pc;
        logic [7:0] tos;
        logic [3:0] sp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_img(input int p);
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        case (p)
            0: begin // sum of mem[25..29]
                for (int i = 0; i < 5; i++) img[i] = 8'h80 | 8'(25 + i);
                for (int i = 5; i < 9; i++) img[i] = 8'h00;
                img[9]  = 8'hBE;
                img[25] = 8'd9; img[26] = 8'd7; img[27] = 8'd5;
                img[28] = 8'd3; img[29] = 8'd1;
            end
            1: begin // sub then jz taken, and/not/pop at 15
                img[0]  = 8'h9D; img[1] = 8'h9D; img[2] = 8'h20; img[3] = 8'hEF;
                img[15] = 8'h9C; img[16] = 8'h9B; img[17] = 8'h40;
                img[18] = 8'h60; img[19] = 8'hBF;
                img[27] = 8'h66; img[28] = 8'hAA; img[29] = 8'd16;
            end
            2: begin // sub ordering, jmp 7 at 3, jz not taken
                img[0] = 8'h94; img[1] = 8'h95; img[2] = 8'h20; img[3] = 8'hC7;
                img[7] = 8'h96; img[8] = 8'hEC; img[9] = 8'hB7;
                img[20] = 8'd9; img[21] = 8'd1; img[22] = 8'd16;
            end
            3: begin // nine pushes
                for (int i = 0; i < 9; i++) img[i] = 8'h99;
                img[25] = 8'd5;
            end
            4: begin // add with one operand
                img[0] = 8'h99; img[1] = 8'h00; img[25] = 8'd5;
            end
            5: begin // pop on empty stack
                img[0] = 8'hBE; img[30] = 8'h5A;
            end
            default: begin // push then pop, reset mid-pop
                img[0] = 8'h99; img[1] = 8'hBE; img[25] = 8'h77; img[30] = 8'h33;
            end
        endcase
    endtask

    task automatic do_reset(input int p);
        run   = 1'b0;
        rst_n = 1'b0;
        set_img(p);
        ld_en = 1'b1;
        tick();
        tick();
        ld_en = 1'b0;
        rst_n = 1'b1;
    endtask

    // Leave IDLE; run is dropped afterwards since it only matters in IDLE.
    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic step();
        tick();
        tick();
    endtask

    task automatic run_prog(input int p);
        logic [4:0] fa;
        fa = 5'd0;
        do_reset(p);
        start();
        foreach (vecs[k]) begin
            if (vecs[k].prog == p) begin
                check("fetch_read", mem_read, 1);
                check("fetch_addr", mem_addr, fa);
                tick();
                check("instr_done", instr_done, 1);
                tick();
                check("pc", pc, vecs[k].pc);
                check("tos", tos, vecs[k].tos);
                check("sp_count", sp_count, vecs[k].sp);
                fa = vecs[k].pc;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        ld_en = 1'b0;

        // {prog, pc, tos, sp} after each instruction's EXEC
        vecs.push_back('{0, 5'd1,  8'd9,  4'd1});
        vecs.push_back('{0, 5'd2,  8'd7,  4'd2});
        vecs.push_back('{0, 5'd3,  8'd5,  4'd3});
        vecs.push_back('{0, 5'd4,  8'd3,  4'd4});
        vecs.push_back('{0, 5'd5,  8'd1,  4'd5});
        vecs.push_back('{0, 5'd6,  8'd4,  4'd4});
        vecs.push_back('{0, 5'd7,  8'd9,  4'd3});
        vecs.push_back('{0, 5'd8,  8'd16, 4'd2});
        vecs.push_back('{0, 5'd9,  8'd25, 4'd1});
        vecs.push_back('{0, 5'd10, 8'd0,  4'd0});
        vecs.push_back('{1, 5'd1,  8'd16, 4'd1});
        vecs.push_back('{1, 5'd2,  8'd16, 4'd2});
        vecs.push_back('{1, 5'd3,  8'd0,  4'd1});
        vecs.push_back('{1, 5'd15, 8'd0,  4'd1});
        vecs.push_back('{1, 5'd16, 8'hAA, 4'd2});
        vecs.push_back('{1, 5'd17, 8'h66, 4'd3});
        vecs.push_back('{1, 5'd18, 8'h22, 4'd2});
        vecs.push_back('{1, 5'd19, 8'hDD, 4'd2}); // ~(0xAA & 0x66)
        vecs.push_back('{1, 5'd20, 8'd0,  4'd1});
        vecs.push_back('{2, 5'd1,  8'd9,  4'd1});
        vecs.push_back('{2, 5'd2,  8'd1,  4'd2});
        vecs.push_back('{2, 5'd3,  8'd8,  4'd1});
        vecs.push_back('{2, 5'd7,  8'd8,  4'd1});
        vecs.push_back('{2, 5'd8,  8'd16, 4'd2});
        vecs.push_back('{2, 5'd9,  8'd16, 4'd2});
        vecs.push_back('{2, 5'd10, 8'd8,  4'd1});

        // Reset state
        do_reset(0);
        check("rst_pc", pc, 0);
        check("rst_sp", sp_count, 0);
        check("rst_tos", tos, 0);
        check("rst_err", stack_err, 0);
        check("rst_halted", halted, 0);
        check("rst_strobes", {mem_read, mem_write, instr_done}, 0);
        check("rst_bus", {mem_addr, mem_wdata}, 0);
        tick();
        check("idle_no_run", mem_read, 0);

        run_prog(0);
        check("sum_mem30", mem[30], 8'h19);
        check("sum_done_cnt", done_cnt, 10);
        check("sum_not_halted", halted, 0);

        run_prog(1);
        check("jz_mem31", mem[31], 8'hDD);

        run_prog(2);
        check("pop_mem23", mem[23], 8'd16);
        check("jz_nt_err", stack_err, 0);

        // Overflow on the ninth push
        do_reset(3);
        start();
        for (int i = 0; i < 8; i++) step();
        check("ovf_pre_sp", sp_count, 8);
        tick();
        check("ovf_exec_read", mem_read, 0);
        check("ovf_exec_done", instr_done, 0);
        tick();
        check("ovf_err", stack_err, 1);
        check("ovf_halted", halted, 1);
        check("ovf_sp", sp_count, 8);
        check("ovf_pc", pc, 9);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick();
            check("ovf_bus_quiet", {mem_read, mem_write}, 0);
            check("ovf_stay_halt", halted, 1);
        end
        run = 1'b0;

        // Underflow: add with a single operand
        do_reset(4);
        start();
        step();
        tick();
        check("udf_add_done", instr_done, 0);
        check("udf_add_strobes", {mem_read, mem_write}, 0);
        tick();
        check("udf_add_halt", {halted, stack_err}, 2'b11);
        check("udf_add_sp", sp_count, 1);
        check("udf_add_tos", tos, 5);

        // Underflow: pop on empty stack
        do_reset(5);
        start();
        tick();
        check("udf_pop_write", mem_write, 0);
        tick();
        check("udf_pop_halt", {halted, stack_err}, 2'b11);
        check("udf_pop_mem", mem[30], 8'h5A);
        check("udf_pop_pc", pc, 1);

        // Reset during the EXEC cycle of a pop
        do_reset(6);
        start();
        step();
        tick();
        check("rp_write_before", mem_write, 1);
        check("rp_wdata_before", mem_wdata, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("rp_write_drop", mem_write, 0);
        check("rp_wdata_drop", mem_wdata, 0);
        check("rp_pc", pc, 0);
        check("rp_sp", sp_count, 0);
        tick();
        check("rp_mem", mem[30], 8'h33);
        rst_n = 1'b1;
        tick();
        check("rp_idle", {mem_read, mem_write, halted}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
